spi_reg_bridge: RTL and testbench
=================================

// Module: spi_reg_bridge
// PURPOSE
//  SPI slave (mode 0, MSB first) that acts as bus initiator for the 8-bit register file.
//  Decodes 16-bit serial frames into single-cycle register writes, or into reads whose
//  data is shifted back out on MISO. Sits between the off-chip host pins and the
//  register file's addr/data/wr_en/data_o interface.
// PARAMETERS
//  SYNC_STAGES  2      synchronizer depth for sclk_i/cs_n_i/mosi_i (min 2)
//  MAX_ADDR     8      number of implemented registers; addresses >= MAX_ADDR are rejected
// PORTS
//  clk        in   1  system clock; must be >= 8x sclk_i frequency
//  rst_n      in   1  asynchronous, active-low reset
//  sclk_i     in   1  SPI clock (async to clk), idle low
//  cs_n_i     in   1  SPI chip select, active low (async)
//  mosi_i     in   1  SPI serial data in (async)
//  miso_o     out  1  SPI serial data out
//  addr_o     out  8  register address to register file
//  wdata_o    out  8  write data to register file
//  wr_en_o    out  1  write strobe, one clk pulse
//  rd_data_i  in   8  read data from register file (valid 1 clk after addr_o changes)
//  busy_o     out  1  high while a frame is in progress (state != IDLE)
//  err_o      out  1  one-clk pulse: frame to out-of-range address
// BEHAVIOUR
//  - Reset: all outputs 0 (miso_o, addr_o, wdata_o, wr_en_o, busy_o, err_o); state IDLE;
//    shift registers and bit counter cleared. Reset mid-frame discards the frame.
//  - sclk_i, cs_n_i, mosi_i each pass SYNC_STAGES flops; edges detected on synced sclk
//    (rise = sync & ~prev, fall = ~sync & prev). All decoding uses synced signals only.
//  - Frame: bit15 = W (1 write, 0 read), bits14:8 = address A[6:0], bits7:0 = data.
//    addr_o = {1'b0, A}. mosi sampled on sclk rise, miso updated on sclk fall.
//  - FSM: IDLE -> CMD on synced cs_n low. CMD: shift 8 bits (4-bit counter).
//    After 8th rise: latch W/A, drive addr_o next clk; -> DATA.
//    DATA: shift 8 bits. After 16th rise -> COMMIT (1 clk) -> WAIT_CS.
//    COMMIT: if W and A < MAX_ADDR: wdata_o <= shifted byte, wr_en_o = 1 for exactly 1 clk
//    (i.e. 2 clks after the synced 16th rise). If A >= MAX_ADDR (read or write): err_o
//    pulses 1 clk instead, no wr_en_o. Read with A < MAX_ADDR: no strobe.
//    WAIT_CS: extra sclk edges ignored; -> IDLE on synced cs_n high.
//  - cs_n high in CMD or DATA: abort -> IDLE same clk, no wr_en_o/err_o, counter cleared.
//  - cs_n high and low between frames: minimum 2 clk high; next frame starts cleanly.
//  - addr_o and wdata_o hold last value between frames; wr_en_o never asserted outside COMMIT.
//  - busy_o = (state != IDLE), registered.
// CONFIGURATION
//  SPI_REG_BRIDGE_READBACK_EN defined: 1 clk after addr_o update, rd_data_i captured into
//    tx shift reg (0x00 if A >= MAX_ADDR); tx bit7 driven on miso_o at the 8th sclk fall,
//    remaining bits on subsequent falls. miso_o = 0 in IDLE, CMD and after bit0.
//  Not defined: read path removed; miso_o tied 0; read frames complete with no effect
//    except err_o for out-of-range address.
// TESTING
//  1 write frame 0x81A5 -> addr_o=0x01, wdata_o=0xA5, wr_en_o high exactly 1 clk, err_o=0.
//  2 (READBACK_EN) read 0x0300, rd_data_i=0x5A -> miso bits 0,1,0,1,1,0,1,0 in data phase,
//    no wr_en_o; macro off -> miso_o stays 0.
//  3 write 0x89FF (A=0x09) -> err_o 1-clk pulse, wr_en_o never high, addr_o=0x09.
//  4 cs_n raised after 12 bits of 0x8277 -> no wr_en_o, busy_o falls; following frame
//    0x8233 -> wdata_o=0x33, single strobe.
//  5 rst_n asserted after 10 bits -> all outputs 0 immediately; post-reset frame 0x8411
//    -> addr_o=0x04, wdata_o=0x11.
//  6 back-to-back writes 0x8001,0x8702 with min cs_n gap, extra sclk pulses in WAIT_CS
//    -> exactly two strobes, correct addr/data each.

Source files
------------

// File: rtl/spi_reg_bridge_if.sv
// Pin/bus bundle for spi_reg_bridge: off-chip SPI pins plus the register-file port.
// The bridge is the bus initiator and takes the master modport; the environment takes slave.
interface spi_reg_bridge_if;
  logic       sclk_i;
  logic       cs_n_i;
  logic       mosi_i;
  logic       miso_o;
  logic [7:0] addr_o;
  logic [7:0] wdata_o;
  logic       wr_en_o;
  logic [7:0] rd_data_i;
  logic       busy_o;
  logic       err_o;

  modport master (
    input  sclk_i, cs_n_i, mosi_i, rd_data_i,
    output miso_o, addr_o, wdata_o, wr_en_o, busy_o, err_o
  );

  modport slave (
    output sclk_i, cs_n_i, mosi_i, rd_data_i,
    input  miso_o, addr_o, wdata_o, wr_en_o, busy_o, err_o
  );
endinterface

// File: rtl/spi_reg_bridge.sv
// SPI mode-0 slave that turns 16-bit frames into register-file writes/reads.
// Define SPI_REG_BRIDGE_READBACK_EN to shift read data back out on miso_o.
module spi_reg_bridge #(
  parameter int SYNC_STAGES = 2,
  parameter int MAX_ADDR    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  spi_reg_bridge_if.master  bus
);

  localparam logic [7:0] MAX_ADDR_L = 8'(MAX_ADDR);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_DATA,
    S_COMMIT,
    S_WAIT_CS
  } state_t;

  state_t     r_state;
  state_t     w_state_next;

  // Each stage holds {sclk, cs_n, mosi}; cs_n resets high so no frame starts out of reset.
  logic [2:0] r_sync [SYNC_STAGES];
  logic       r_sclk_prev;
  logic       w_sclk_s;
  logic       w_cs_n_s;
  logic       w_mosi_s;
  logic       w_rise;
  logic       w_fall;

  logic [7:0] r_rx_shift;
  logic [3:0] r_bit_cnt;
  logic       r_cmd_w;
  logic [6:0] r_cmd_addr;
  logic [7:0] r_addr;
  logic [7:0] r_wdata;
  logic       r_wr_en;
  logic       r_err;
  logic       r_busy;
  logic       w_addr_ok;
  logic       w_cmd_done;
  logic       w_wr_en_next;
  logic       w_err_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync[0] <= 3'b010;
    end else begin
      r_sync[0] <= {bus.sclk_i, bus.cs_n_i, bus.mosi_i};
    end
  end

  generate
    for (genvar gi = 1; gi < SYNC_STAGES; gi++) begin : g_sync
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_sync[gi] <= 3'b010;
        end else begin
          r_sync[gi] <= r_sync[gi-1];
        end
      end
    end
  endgenerate

  assign w_sclk_s  = r_sync[SYNC_STAGES-1][2];
  assign w_cs_n_s  = r_sync[SYNC_STAGES-1][1];
  assign w_mosi_s  = r_sync[SYNC_STAGES-1][0];
  assign w_rise    = w_sclk_s & ~r_sclk_prev;
  assign w_fall    = ~w_sclk_s & r_sclk_prev;
  assign w_addr_ok = ({1'b0, r_cmd_addr} < MAX_ADDR_L);

  always_comb begin
    w_state_next = r_state;
    w_cmd_done   = 1'b0;
    w_wr_en_next = 1'b0;
    w_err_next   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_cs_n_s) w_state_next = S_CMD;
      end
      S_CMD: begin
        if (w_cs_n_s) begin
          w_state_next = S_IDLE;
        end else if (w_rise && r_bit_cnt == 4'd7) begin
          w_state_next = S_DATA;
          w_cmd_done   = 1'b1;
        end
      end
      S_DATA: begin
        if (w_cs_n_s) begin
          w_state_next = S_IDLE;
        end else if (w_rise && r_bit_cnt == 4'd7) begin
          w_state_next = S_COMMIT;
        end
      end
      S_COMMIT: begin
        w_state_next = S_WAIT_CS;
        if (!w_addr_ok) begin
          w_err_next = 1'b1;
        end else if (r_cmd_w) begin
          w_wr_en_next = 1'b1;
        end
      end
      S_WAIT_CS: begin
        if (w_cs_n_s) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_sclk_prev <= 1'b0;
      r_rx_shift  <= '0;
      r_bit_cnt   <= '0;
      r_cmd_w     <= 1'b0;
      r_cmd_addr  <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wr_en     <= 1'b0;
      r_err       <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_sclk_prev <= w_sclk_s;
      r_wr_en     <= w_wr_en_next;
      r_err       <= w_err_next;
      r_busy      <= (w_state_next != S_IDLE);

      // The bit counter wraps every byte; an abort clears it so the next frame starts at bit 15.
      if ((r_state == S_CMD || r_state == S_DATA) && !w_cs_n_s) begin
        if (w_rise) begin
          r_rx_shift <= {r_rx_shift[6:0], w_mosi_s};
          r_bit_cnt  <= (r_bit_cnt == 4'd7) ? 4'd0 : r_bit_cnt + 4'd1;
        end
      end else begin
        r_bit_cnt <= '0;
      end

      if (w_cmd_done) begin
        r_cmd_w    <= r_rx_shift[6];
        r_cmd_addr <= {r_rx_shift[5:0], w_mosi_s};
        r_addr     <= {1'b0, r_rx_shift[5:0], w_mosi_s};
      end

      if (w_wr_en_next) begin
        r_wdata <= r_rx_shift;
      end
    end
  end

  assign bus.addr_o  = r_addr;
  assign bus.wdata_o = r_wdata;
  assign bus.wr_en_o = r_wr_en;
  assign bus.err_o   = r_err;
  assign bus.busy_o  = r_busy;

`ifdef SPI_REG_BRIDGE_READBACK_EN
  logic       r_load_pend;
  logic [7:0] r_tx_shift;
  logic       r_miso;

  // rd_data_i is taken the clk after addr_o updates; the first data-phase fall is several clks later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_load_pend <= 1'b0;
      r_tx_shift  <= '0;
      r_miso      <= 1'b0;
    end else begin
      r_load_pend <= w_cmd_done;
      if (r_state == S_IDLE || r_state == S_CMD) begin
        r_tx_shift <= '0;
        r_miso     <= 1'b0;
      end else if (r_load_pend) begin
        r_tx_shift <= w_addr_ok ? bus.rd_data_i : 8'h00;
      end else if (w_fall) begin
        r_miso     <= r_tx_shift[7];
        r_tx_shift <= {r_tx_shift[6:0], 1'b0};
      end
    end
  end

  assign bus.miso_o = r_miso;
`else
  logic w_unused_rd_data;
  assign w_unused_rd_data = ^bus.rd_data_i;
  assign bus.miso_o       = 1'b0;
`endif

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Directed bench for spi_reg_bridge: hand-computed frames, strobe monitor, one line per frame.
// Build with or without SPI_REG_BRIDGE_READBACK_EN; readback expectations follow the macro.
module tb_spi_reg_bridge;
  localparam int HALF = 8;

  logic clk;
  logic rst_n;
  spi_reg_bridge_if bus ();

  spi_reg_bridge #(.SYNC_STAGES(2), .MAX_ADDR(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors;
  int miscompares;
  int wr_cnt, wr_run, wr_max;
  int err_cnt, err_run, err_max;
  logic [15:0] strobe_log [$];

  initial begin
    vectors = 0; miscompares = 0;
    wr_cnt = 0; wr_run = 0; wr_max = 0;
    err_cnt = 0; err_run = 0; err_max = 0;
  end

  always @(negedge clk) begin
    if (bus.wr_en_o === 1'b1) begin
      wr_run++;
      if (wr_run == 1) begin
        wr_cnt++;
        strobe_log.push_back({bus.addr_o, bus.wdata_o});
      end
      if (wr_run > wr_max) wr_max = wr_run;
    end else begin
      wr_run = 0;
    end
    if (bus.err_o === 1'b1) begin
      err_run++;
      if (err_run == 1) err_cnt++;
      if (err_run > err_max) err_max = err_run;
    end else begin
      err_run = 0;
    end
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic half_bit();
    repeat (HALF) @(negedge clk);
  endtask

  task automatic spi_frame(input logic [15:0] f, input int nbits, input int extra,
                           output logic [7:0] m);
    m = '0;
    bus.cs_n_i = 1'b0;
    half_bit();
    for (int i = 15; i > 15 - nbits; i--) begin
      bus.mosi_i = f[i];
      half_bit();
      if (i < 8) m[i] = bus.miso_o;
      bus.sclk_i = 1'b1;
      half_bit();
      bus.sclk_i = 1'b0;
    end
    half_bit();
    for (int k = 0; k < extra; k++) begin
      bus.sclk_i = 1'b1;
      half_bit();
      bus.sclk_i = 1'b0;
      half_bit();
    end
    $display("frame %h bits=%0d extra=%0d miso=%h addr=%h wdata=%h strobes=%0d errs=%0d",
             f, nbits, extra, m, bus.addr_o, bus.wdata_o, wr_cnt, err_cnt);
  endtask

  task automatic end_frame(input int gap);
    bus.cs_n_i = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  logic [7:0] miso_bits;
  logic [7:0] exp_rb;

  initial begin
    rst_n         = 1'b0;
    bus.sclk_i    = 1'b0;
    bus.cs_n_i    = 1'b1;
    bus.mosi_i    = 1'b0;
    bus.rd_data_i = 8'h00;
    repeat (4) @(negedge clk);
    check("rst_miso",  {15'd0, bus.miso_o},  16'h0000);
    check("rst_addr",  {8'd0, bus.addr_o},   16'h0000);
    check("rst_wdata", {8'd0, bus.wdata_o},  16'h0000);
    check("rst_wr_en", {15'd0, bus.wr_en_o}, 16'h0000);
    check("rst_busy",  {15'd0, bus.busy_o},  16'h0000);
    check("rst_err",   {15'd0, bus.err_o},   16'h0000);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // 1: plain write
    spi_frame(16'h81A5, 16, 0, miso_bits);
    check("t1_busy_in_frame", {15'd0, bus.busy_o}, 16'h0001);
    end_frame(6);
    check("t1_busy_after", {15'd0, bus.busy_o}, 16'h0000);
    check("t1_strobes", 16'(wr_cnt), 16'd1);
    check("t1_addr",    {8'd0, bus.addr_o},  16'h0001);
    check("t1_wdata",   {8'd0, bus.wdata_o}, 16'h00A5);
    check("t1_errs",    16'(err_cnt), 16'd0);

    // 2: in-range read
    bus.rd_data_i = 8'h5A;
`ifdef SPI_REG_BRIDGE_READBACK_EN
    exp_rb = 8'h5A;
`else
    exp_rb = 8'h00;
`endif
    spi_frame(16'h0300, 16, 0, miso_bits);
    check("t2_miso_bits", {8'd0, miso_bits}, {8'd0, exp_rb});
    check("t2_miso_idle", {15'd0, bus.miso_o}, 16'h0000);
    end_frame(6);
    check("t2_addr",    {8'd0, bus.addr_o}, 16'h0003);
    check("t2_strobes", 16'(wr_cnt), 16'd1);
    check("t2_errs",    16'(err_cnt), 16'd0);

    // 3: out-of-range write
    spi_frame(16'h89FF, 16, 0, miso_bits);
    end_frame(6);
    check("t3_errs",    16'(err_cnt), 16'd1);
    check("t3_strobes", 16'(wr_cnt), 16'd1);
    check("t3_addr",    {8'd0, bus.addr_o},  16'h0009);
    check("t3_wdata",   {8'd0, bus.wdata_o}, 16'h00A5);

    // 4: abort after 12 bits, then a clean frame
    spi_frame(16'h8277, 12, 0, miso_bits);
    bus.cs_n_i = 1'b1;
    repeat (4) @(negedge clk);
    check("t4_busy_abort",   {15'd0, bus.busy_o}, 16'h0000);
    check("t4_abort_strobe", 16'(wr_cnt), 16'd1);
    repeat (4) @(negedge clk);
    spi_frame(16'h8233, 16, 0, miso_bits);
    end_frame(6);
    check("t4_strobes", 16'(wr_cnt), 16'd2);
    check("t4_addr",    {8'd0, bus.addr_o},  16'h0002);
    check("t4_wdata",   {8'd0, bus.wdata_o}, 16'h0033);

    // 5: reset mid-frame
    spi_frame(16'h8555, 10, 0, miso_bits);
    rst_n = 1'b0;
    #1;
    check("t5_rst_addr",  {8'd0, bus.addr_o},  16'h0000);
    check("t5_rst_wdata", {8'd0, bus.wdata_o}, 16'h0000);
    check("t5_rst_busy",  {15'd0, bus.busy_o}, 16'h0000);
    check("t5_rst_miso",  {15'd0, bus.miso_o}, 16'h0000);
    bus.cs_n_i = 1'b1;
    bus.sclk_i = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    spi_frame(16'h8411, 16, 0, miso_bits);
    end_frame(6);
    check("t5_addr",    {8'd0, bus.addr_o},  16'h0004);
    check("t5_wdata",   {8'd0, bus.wdata_o}, 16'h0011);
    check("t5_strobes", 16'(wr_cnt), 16'd3);

    // 6: back-to-back with minimum gap and stray sclk pulses in WAIT_CS
    spi_frame(16'h8001, 16, 2, miso_bits);
    end_frame(2);
    spi_frame(16'h8702, 16, 2, miso_bits);
    end_frame(6);
    check("t6_strobes", 16'(wr_cnt), 16'd5);
    if (strobe_log.size() == 5) begin
      check("t6_first",  strobe_log[3], 16'h0001);
      check("t6_second", strobe_log[4], 16'h0702);
    end else begin
      check("t6_log_size", 16'(strobe_log.size()), 16'd5);
    end
    check("t6_errs",    16'(err_cnt), 16'd1);
    check("wr_width",   16'(wr_max),  16'd1);
    check("err_width",  16'(err_max), 16'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
